// File: rtl/norm_shift.sv
// Post-add significand normaliser: right-shifts on carry-out, left-shifts until the hidden bit is set,
// and reports the exponent adjustment for the downstream exponent-adjust stage.
module norm_shift (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [24:0] mant_in,
  input  logic [7:0]  exp_in,
  output logic        busy,
  output logic        done,
  output logic [22:0] mant_out,
  output logic [7:0]  exp_out,
  output logic [7:0]  incre_bit,
  output logic [7:0]  decre_bit,
  output logic        incre_en,
  output logic        decre_en,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [24:0] mant_q, mant_d;
  logic [7:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [22:0] mant_out_q, mant_out_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  incre_bit_q, incre_bit_d;
  logic [7:0]  decre_bit_q, decre_bit_d;
  logic        incre_en_q, incre_en_d;
  logic        decre_en_q, decre_en_d;
  logic        zero_q, zero_d;
  logic [24:0] mant_shl;
  logic [7:0]  count_inc;

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    count_d     = count_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mant_out_d  = mant_out_q;
    exp_d       = exp_q;
    incre_bit_d = incre_bit_q;
    decre_bit_d = decre_bit_q;
    incre_en_d  = incre_en_q;
    decre_en_d  = decre_en_q;
    zero_d      = zero_q;
    mant_shl    = {mant_q[23:0], 1'b0};
    count_inc   = count_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          mant_d  = mant_in;
          exp_d   = exp_in;
          count_d = 8'd0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end

      CHECK: begin
        zero_d      = 1'b0;
        incre_en_d  = 1'b0;
        decre_en_d  = 1'b0;
        incre_bit_d = 8'd0;
        decre_bit_d = 8'd0;
        if (mant_q == 25'd0) begin
          zero_d     = 1'b1;
          mant_out_d = 23'd0;
          state_d    = DONE;
        end else if (mant_q[24]) begin
          mant_d      = {1'b0, mant_q[24:1]};
          incre_bit_d = 8'd1;
          incre_en_d  = 1'b1;
          state_d     = DONE;
        end else if (mant_q[23] || exp_q == 8'd0) begin
          // exp==0 with no hidden bit is a denormal: leave it untouched
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        mant_d  = mant_shl;
        count_d = count_inc;
        // Stop at the exponent so the adjusted exponent clamps at zero
        if (mant_shl[23] || count_inc == exp_q) begin
          decre_bit_d = count_inc;
          decre_en_d  = 1'b1;
          incre_bit_d = 8'd0;
          incre_en_d  = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        mant_out_d = mant_q[22:0];
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      mant_q      <= 25'd0;
      count_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mant_out_q  <= 23'd0;
      exp_q       <= 8'd0;
      incre_bit_q <= 8'd0;
      decre_bit_q <= 8'd0;
      incre_en_q  <= 1'b0;
      decre_en_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mant_out_q  <= mant_out_d;
      exp_q       <= exp_d;
      incre_bit_q <= incre_bit_d;
      decre_bit_q <= decre_bit_d;
      incre_en_q  <= incre_en_d;
      decre_en_q  <= decre_en_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mant_out  = mant_out_q;
  assign exp_out   = exp_q;
  assign incre_bit = incre_bit_q;
  assign decre_bit = decre_bit_q;
  assign incre_en  = incre_en_q;
  assign decre_en  = decre_en_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_norm_shift.sv
// Directed bench for norm_shift: hand-computed vectors for carry, normalised, zero, max shift,
// underflow clamp, denormal and mid-operation reset, checked with immediate assertions.
module tb_norm_shift;

  logic        clk;
  logic        res;
  logic        start;
  logic [24:0] mant_in;
  logic [7:0]  exp_in;
  logic        busy;
  logic        done;
  logic [22:0] mant_out;
  logic [7:0]  exp_out;
  logic [7:0]  incre_bit;
  logic [7:0]  decre_bit;
  logic        incre_en;
  logic        decre_en;
  logic        zero;

  int compared = 0;
  int mismatched = 0;

  norm_shift dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .busy      (busy),
    .done      (done),
    .mant_out  (mant_out),
    .exp_out   (exp_out),
    .incre_bit (incre_bit),
    .decre_bit (decre_bit),
    .incre_en  (incre_en),
    .decre_en  (decre_en),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Launch one operation and count edges until done rises; midEdge injects a start that must be ignored
  task automatic applyStimulus(input string tag, input logic [24:0] m, input logic [7:0] e,
                               input int midEdge, input int expEdges);
    int edges;
    bit seen;
    edges = 0;
    seen = 1'b0;
    mant_in = m;
    exp_in = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_busy_accept"}, 32'(busy), 32'd1);
    while (!seen && edges < 40) begin
      if (edges == midEdge) begin
        start = 1'b1;
        mant_in = 25'h1000000;
        exp_in = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (done) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'(expEdges));
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    res = 1'b0;
    start = 1'b0;
    mant_in = 25'd0;
    exp_in = 8'd0;
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd0);
    checkOutput("rst_mant_out", 32'(mant_out), 32'd0);
    checkOutput("rst_exp_out", 32'(exp_out), 32'd0);
    checkOutput("rst_enables", {30'd0, incre_en, decre_en}, 32'd0);
    checkOutput("rst_amounts", {16'd0, incre_bit, decre_bit}, 32'd0);
    @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;

    applyStimulus("carry", 25'h1000000, 8'h80, -1, 2);
    checkOutput("carry_incre_en", 32'(incre_en), 32'd1);
    checkOutput("carry_incre_bit", 32'(incre_bit), 32'd1);
    checkOutput("carry_decre_en", 32'(decre_en), 32'd0);
    checkOutput("carry_mant_out", 32'(mant_out), 32'h000000);
    checkOutput("carry_exp_out", 32'(exp_out), 32'h80);
    checkOutput("carry_zero", 32'(zero), 32'd0);

    // Back-to-back: start in the done cycle is accepted; start during DONE state is ignored
    applyStimulus("norm", 25'h0C00000, 8'd10, 1, 2);
    checkOutput("norm_incre_en", 32'(incre_en), 32'd0);
    checkOutput("norm_decre_en", 32'(decre_en), 32'd0);
    checkOutput("norm_incre_bit", 32'(incre_bit), 32'd0);
    checkOutput("norm_mant_out", 32'(mant_out), 32'h400000);
    checkOutput("norm_exp_out", 32'(exp_out), 32'd10);
    @(posedge clk); #1;
    checkOutput("norm_done_pulse", 32'(done), 32'd0);
    checkOutput("norm_idle_busy", 32'(busy), 32'd0);
    checkOutput("norm_hold_mant", 32'(mant_out), 32'h400000);

    applyStimulus("zero", 25'h0000000, 8'h40, -1, 2);
    checkOutput("zero_flag", 32'(zero), 32'd1);
    checkOutput("zero_enables", {30'd0, incre_en, decre_en}, 32'd0);
    checkOutput("zero_amounts", {16'd0, incre_bit, decre_bit}, 32'd0);
    checkOutput("zero_mant_out", 32'(mant_out), 32'd0);

    applyStimulus("maxshift", 25'h0000001, 8'h7F, 10, 25);
    checkOutput("maxshift_decre_en", 32'(decre_en), 32'd1);
    checkOutput("maxshift_decre_bit", 32'(decre_bit), 32'd23);
    checkOutput("maxshift_incre_en", 32'(incre_en), 32'd0);
    checkOutput("maxshift_mant_out", 32'(mant_out), 32'h000000);
    checkOutput("maxshift_exp_out", 32'(exp_out), 32'h7F);
    checkOutput("maxshift_zero", 32'(zero), 32'd0);

    applyStimulus("clamp", 25'h0000100, 8'd5, -1, 7);
    checkOutput("clamp_decre_en", 32'(decre_en), 32'd1);
    checkOutput("clamp_decre_bit", 32'(decre_bit), 32'd5);
    checkOutput("clamp_mant_out", 32'(mant_out), 32'h002000);

    applyStimulus("denorm", 25'h0000100, 8'd0, -1, 2);
    checkOutput("denorm_enables", {30'd0, incre_en, decre_en}, 32'd0);
    checkOutput("denorm_amounts", {16'd0, incre_bit, decre_bit}, 32'd0);
    checkOutput("denorm_mant_out", 32'(mant_out), 32'h000100);
    checkOutput("denorm_zero", 32'(zero), 32'd0);

    // Reset in the middle of a long shift sequence
    mant_in = 25'h0000001;
    exp_in = 8'h7F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    res = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_exp_out", 32'(exp_out), 32'd0);
    checkOutput("abort_mant_out", 32'(mant_out), 32'd0);
    checkOutput("abort_flags", {29'd0, incre_en, decre_en, zero}, 32'd0);
    checkOutput("abort_amounts", {16'd0, incre_bit, decre_bit}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_idle_busy", {31'd0, busy | done}, 32'd0);
    applyStimulus("post", 25'h0C00000, 8'd10, -1, 2);
    checkOutput("post_mant_out", 32'(mant_out), 32'h400000);
    checkOutput("post_exp_out", 32'(exp_out), 32'd10);
    checkOutput("post_enables", {30'd0, incre_en, decre_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
